// File: rtl/skolem_pkg.sv
// Shared types, constants and sizing helpers for the bvadd-inverse Skolem sweep stage.
package skolem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    localparam int SWEEP_W = 4;
    localparam int NVEC    = 1 << (2 * SWEEP_W);
    localparam int LAT_MAX = 3;

    // Counter width: 2W+1 bits holds the full vector count 2^(2W) without wrapping.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/skolem_delay_line.sv
// LAT-deep register pipeline carrying {vld, s, t} alongside the Skolem block latency; LAT=0 is a wire.
module skolem_delay_line #(
    parameter int LAT = 0,
    parameter int DW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_s;
            assign unused_s = clk ^ rst;
            assign dout     = din;
        end else begin : g_pipe
            logic [DW-1:0] pipe_r [LAT];

            // Shift the vector one stage per cycle; reset clears all stages so no stale vld escapes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        pipe_r[i] <= '0;
                    end
                end else begin
                    pipe_r[0] <= din;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign dout = pipe_r[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/skolem_bvadd_sweep.sv
// Exhaustive (s,t) stimulus plus x+s==t response checker for a W-bit bvadd-inverse Skolem block.
// Build option: SWEEP_STOP_ON_FAIL_EN ends the sweep early after the first registered mismatch.
module skolem_bvadd_sweep
    import skolem_pkg::*;
#(
    parameter int W   = 4,
    parameter int LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [W-1:0]        s_out,
    output logic [W-1:0]        t_out,
    output logic                vec_vld,
    input  logic [W-1:0]        x_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [cnt_w(W)-1:0] chk_cnt,
    output logic [cnt_w(W)-1:0] fail_cnt,
    output logic                ff_vld,
    output logic [W-1:0]        ff_s,
    output logic [W-1:0]        ff_t,
    output logic [W-1:0]        ff_x
);

    localparam int CW = cnt_w(W);
    localparam int IW = 2 * W;
    localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};

    sweep_state_e   state_r, state_nxt_s;
    logic [IW-1:0]  idx_r;
    logic [1:0]     drain_cnt_r;
    logic           start_ok_s;
    logic           vec_vld_r, busy_r, done_r, pass_r;
    logic           vld_d_s;
    logic [W-1:0]   s_d_s, t_d_s, sum_s;
    logic           mismatch_s;
    logic           cmp_vld_r, cmp_fail_r;
    logic [W-1:0]   cmp_s_r, cmp_t_r, cmp_x_r;
    logic [CW-1:0]  chk_cnt_r, fail_cnt_r;
    logic           ff_vld_r;
    logic [W-1:0]   ff_s_r, ff_t_r, ff_x_r;

    assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));

    // Next-state logic for the sweep controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
`ifdef SWEEP_STOP_ON_FAIL_EN
                if ((idx_r == IDX_LAST) || cmp_fail_r) state_nxt_s = DRAIN;
                else                                   state_nxt_s = RUN;
`else
                if (idx_r == IDX_LAST) state_nxt_s = DRAIN;
                else                   state_nxt_s = RUN;
`endif
            end
            DRAIN: begin
                if (drain_cnt_r == 2'(LAT)) state_nxt_s = DONE;
                else                        state_nxt_s = DRAIN;
            end
            DONE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Controller state, vector index, drain timer and the status outputs derived from them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            drain_cnt_r <= 2'd0;
            vec_vld_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            if (start_ok_s)            idx_r <= '0;
            else if (state_r == RUN)   idx_r <= idx_r + IW'(1);
            drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + 2'd1 : 2'd0;
            vec_vld_r   <= (state_nxt_s == RUN);
            busy_r      <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
            // One cycle in DONE lets the last counter update settle before done/pass rise.
            done_r      <= (state_r == DONE) && (state_nxt_s == DONE);
            pass_r      <= (state_r == DONE) && (state_nxt_s == DONE) && (fail_cnt_r == '0);
        end
    end

    assign s_out   = idx_r[W-1:0];
    assign t_out   = idx_r[IW-1:W];
    assign vec_vld = vec_vld_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign pass    = pass_r;

    skolem_delay_line #(
        .LAT (LAT),
        .DW  (2 * W + 1)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({vec_vld_r, s_out, t_out}),
        .dout ({vld_d_s, s_d_s, t_d_s})
    );

    assign sum_s      = x_in + s_d_s;
    assign mismatch_s = vld_d_s && (sum_s != t_d_s);

    // Register the compare result together with the vector it judged.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_r  <= 1'b0;
            cmp_fail_r <= 1'b0;
            cmp_s_r    <= '0;
            cmp_t_r    <= '0;
            cmp_x_r    <= '0;
        end else begin
            cmp_vld_r  <= vld_d_s;
            cmp_fail_r <= mismatch_s;
            cmp_s_r    <= s_d_s;
            cmp_t_r    <= t_d_s;
            cmp_x_r    <= x_in;
        end
    end

    // Result counters and first-fail record; a fresh sweep clears them.
    always_ff @(posedge clk) begin
        if (rst || start_ok_s) begin
            chk_cnt_r  <= '0;
            fail_cnt_r <= '0;
            ff_vld_r   <= 1'b0;
            ff_s_r     <= '0;
            ff_t_r     <= '0;
            ff_x_r     <= '0;
        end else begin
            if (cmp_vld_r)  chk_cnt_r  <= chk_cnt_r + CW'(1);
            if (cmp_fail_r) fail_cnt_r <= fail_cnt_r + CW'(1);
            if (cmp_fail_r && !ff_vld_r) begin
                ff_vld_r <= 1'b1;
                ff_s_r   <= cmp_s_r;
                ff_t_r   <= cmp_t_r;
                ff_x_r   <= cmp_x_r;
            end
        end
    end

    assign chk_cnt  = chk_cnt_r;
    assign fail_cnt = fail_cnt_r;
    assign ff_vld   = ff_vld_r;
    assign ff_s     = ff_s_r;
    assign ff_t     = ff_t_r;
    assign ff_x     = ff_x_r;

endmodule

// File: tb/tb_skolem_bvadd_sweep.sv
// Directed bench: one LAT=0 instance with selectable Skolem models, one LAT=2 instance with a golden pipeline.
module tb_skolem_bvadd_sweep;

    localparam int W  = 4;
    localparam int CW = 2 * W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst0, start0, vld0, busy0, done0, pass0, ffv0;
    logic [W-1:0]  s0, t0, x0, ffs0, fft0, ffx0;
    logic [CW-1:0] chk0, fail0;
    logic          rst2, start2, vld2, busy2, done2, pass2, ffv2;
    logic [W-1:0]  s2, t2, x2, ffs2, fft2, ffx2, p1, p2;
    logic [CW-1:0] chk2, fail2;

    int mode;
    int nvec = 0;
    int nmis = 0;
    int n;

    skolem_bvadd_sweep #(.W(W), .LAT(0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .s_out(s0), .t_out(t0), .vec_vld(vld0),
        .x_in(x0), .busy(busy0), .done(done0), .pass(pass0), .chk_cnt(chk0), .fail_cnt(fail0),
        .ff_vld(ffv0), .ff_s(ffs0), .ff_t(fft0), .ff_x(ffx0)
    );

    skolem_bvadd_sweep #(.W(W), .LAT(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .s_out(s2), .t_out(t2), .vec_vld(vld2),
        .x_in(x2), .busy(busy2), .done(done2), .pass(pass2), .chk_cnt(chk2), .fail_cnt(fail2),
        .ff_vld(ffv2), .ff_s(ffs2), .ff_t(fft2), .ff_x(ffx2)
    );

    // Mode 0 golden x=t-s, mode 1 x stuck at 0, mode 2 golden except (s=3,t=5).
    always_comb begin
        x0 = t0 - s0;
        if (mode == 1) x0 = '0;
        else if (mode == 2 && s0 == 4'd3 && t0 == 4'd5) x0 = '0;
        else x0 = t0 - s0;
    end

    // Golden model registered twice to match LAT=2.
    always_ff @(posedge clk) begin
        p1 <= t2 - s2;
        p2 <= p1;
    end
    assign x2 = p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then count cycles until done; optionally re-pulse start mid-sweep.
    task automatic run(input int sel, input int mid, output int cyc);
        logic d;
        @(negedge clk);
        if (sel != 0) start2 = 1'b1;
        else          start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        if (sel != 0) chk("first_vld", 32'(vld2), 32'd1);
        else          chk("first_vec", 32'({vld0, t0, s0}), 32'h100);
        cyc = 0;
        d   = 1'b0;
        while (!d && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            d = (sel != 0) ? done2 : done0;
            start0 = (mid != 0 && cyc == mid) ? 1'b1 : 1'b0;
        end
        start0 = 1'b0;
        chk("done_seen", 32'(d), 32'd1);
    endtask

    initial begin
        mode   = 0;
        rst0   = 1'b1;
        rst2   = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", 32'({busy0, done0, pass0, ffv0, vld0}), 32'd0);
        chk("rst_cnt", 32'({chk0, fail0}), 32'd0);
        chk("rst_vec", 32'({s0, t0, ffs0, fft0, ffx0}), 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        rst2 = 1'b0;

        mode = 0;
        run(0, 0, n);
        chk("gold_lat", 32'(n), 32'd258);
        chk("gold_chk", 32'(chk0), 32'd256);
        chk("gold_fail", 32'(fail0), 32'd0);
        chk("gold_pass", 32'({pass0, ffv0, busy0}), 32'b100);

`ifndef SWEEP_STOP_ON_FAIL_EN
        mode = 1;
        run(0, 0, n);
        chk("zero_lat", 32'(n), 32'd258);
        chk("zero_chk", 32'(chk0), 32'd256);
        chk("zero_fail", 32'(fail0), 32'd240);
        chk("zero_ff", 32'({ffv0, ffs0, fft0, ffx0}), 32'h1100);
        chk("zero_pass", 32'(pass0), 32'd0);

        mode = 2;
        run(0, 0, n);
        chk("one_fail", 32'(fail0), 32'd1);
        chk("one_ff", 32'({ffv0, ffs0, fft0, ffx0}), 32'h1350);
        chk("one_pass", 32'(pass0), 32'd0);

        mode = 0;
        run(1, 0, n);
        chk("lat2_lat", 32'(n), 32'd260);
        chk("lat2_chk", 32'(chk2), 32'd256);
        chk("lat2_fail", 32'(fail2), 32'd0);
        chk("lat2_pass", 32'(pass2), 32'd1);

        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("idx100", 32'({vld0, t0, s0}), 32'h164);
        @(negedge clk);
        rst0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_status", 32'({busy0, done0, pass0, ffv0, vld0}), 32'd0);
        chk("mid_rst_cnt", 32'({chk0, fail0}), 32'd0);
        chk("mid_rst_vec", 32'({s0, t0}), 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        run(0, 50, n);
        chk("restart_lat", 32'(n), 32'd258);
        chk("restart_chk", 32'(chk0), 32'd256);
        chk("restart_pass", 32'(pass0), 32'd1);
`else
        mode = 1;
        run(0, 0, n);
        chk("stop_lat", 32'(n), 32'd5);
        chk("stop_chk", 32'(chk0), 32'd3);
        chk("stop_fail", 32'(fail0), 32'd2);
        chk("stop_ff", 32'({ffv0, ffs0, fft0, ffx0}), 32'h1100);
        chk("stop_pass", 32'({pass0, busy0}), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
